// File: rtl/fb_write_arbiter_if.sv
// Framebuffer write-port bundle: two pixel requesters, clear control, blanking and the VGA write port.
interface fb_write_arbiter_if #(
    parameter int PIXEL_WIDTH = 12,
    parameter int ADDR_WIDTH  = 32
);
    logic                   blank;
    logic                   clear_start;
    logic [PIXEL_WIDTH-1:0] clear_value;
    logic                   clear_busy;
    logic                   req0_valid;
    logic                   req0_ready;
    logic [ADDR_WIDTH-1:0]  req0_addr;
    logic [PIXEL_WIDTH-1:0] req0_pixel;
    logic                   req1_valid;
    logic                   req1_ready;
    logic [ADDR_WIDTH-1:0]  req1_addr;
    logic [PIXEL_WIDTH-1:0] req1_pixel;
    logic                   oor_err;
    logic                   write_enable;
    logic [ADDR_WIDTH-1:0]  write_addr;
    logic [PIXEL_WIDTH-1:0] pixel_in;

    // Requesters / timing source side.
    modport master (
        output blank, clear_start, clear_value,
        output req0_valid, req0_addr, req0_pixel,
        output req1_valid, req1_addr, req1_pixel,
        input  clear_busy, req0_ready, req1_ready, oor_err,
        input  write_enable, write_addr, pixel_in
    );

    // Arbiter side.
    modport slave (
        input  blank, clear_start, clear_value,
        input  req0_valid, req0_addr, req0_pixel,
        input  req1_valid, req1_addr, req1_pixel,
        output clear_busy, req0_ready, req1_ready, oor_err,
        output write_enable, write_addr, pixel_in
    );
endinterface

// File: rtl/fb_write_arbiter.sv
// Round-robin arbiter for the VGA framebuffer write port, with a full-screen clear engine
// and optional restriction of all writes to blanking intervals.
module fb_write_arbiter #(
    parameter int PIXEL_WIDTH = 12,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_SIZE    = 2500,
    parameter bit BLANK_ONLY  = 1'b0
) (
    input logic               clk,
    input logic               reset,
    fb_write_arbiter_if.slave bus
);
    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [ADDR_WIDTH-1:0] DEPTH     = ADDR_WIDTH'(MEM_SIZE);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);

    state_t                 state;
    logic                   ptr;        // 1: req1 wins the next tie
    logic [ADDR_WIDTH-1:0]  clr_cnt;
    logic [PIXEL_WIDTH-1:0] clr_val;

    logic                   gate;
    logic                   arb_ok;
    logic                   grant0;
    logic                   grant1;
    logic                   in_range;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [PIXEL_WIDTH-1:0] sel_pixel;

    // clear_start takes priority over any pending request in the same cycle.
    always_comb begin
        gate      = !BLANK_ONLY || bus.blank;
        arb_ok    = (state == IDLE) && gate && !bus.clear_start;
        grant0    = arb_ok && bus.req0_valid && (!bus.req1_valid || !ptr);
        grant1    = arb_ok && bus.req1_valid && (!bus.req0_valid || ptr);
        sel_addr  = grant1 ? bus.req1_addr  : bus.req0_addr;
        sel_pixel = grant1 ? bus.req1_pixel : bus.req0_pixel;
        in_range  = sel_addr < DEPTH;
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            ptr              <= 1'b0;
            bus.write_enable <= 1'b0;
            bus.write_addr   <= '0;
            bus.pixel_in     <= '0;
            bus.clear_busy   <= 1'b0;
            bus.oor_err      <= 1'b0;
        end else begin
            bus.write_enable <= 1'b0;
            bus.oor_err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.clear_start) begin
                        state          <= CLEAR;
                        bus.clear_busy <= 1'b1;
                        clr_cnt        <= '0;
                        clr_val        <= bus.clear_value;
                    end else if (grant0 || grant1) begin
                        ptr              <= grant0;
                        bus.write_enable <= in_range;
                        bus.oor_err      <= !in_range;
                        bus.write_addr   <= sel_addr;
                        bus.pixel_in     <= sel_pixel;
                    end
                end
                CLEAR: begin
                    if (gate) begin
                        bus.write_enable <= 1'b1;
                        bus.write_addr   <= clr_cnt;
                        bus.pixel_in     <= clr_val;
                        clr_cnt          <= clr_cnt + 1'b1;
                        if (clr_cnt == LAST_ADDR) begin
                            state          <= IDLE;
                            bus.clear_busy <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fb_write_arbiter.sv
// Bench for fb_write_arbiter: two instances (BLANK_ONLY=0 and 1) share stimulus and are
// checked every cycle against a rule-level model, plus directed literal expectations.
module tb_fb_write_arbiter;
    localparam int PW  = 12;
    localparam int AW  = 32;
    localparam int MEM = 2500;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          blank = 1'b1;
    logic          clear_start = 1'b0;
    logic [PW-1:0] clear_value = '0;
    logic          v0 = 1'b0, v1 = 1'b0;
    logic [AW-1:0] a0 = '0, a1 = '0;
    logic [PW-1:0] p0 = '0, p1 = '0;

    always #5 clk = ~clk;

    fb_write_arbiter_if #(.PIXEL_WIDTH(PW), .ADDR_WIDTH(AW)) bus0 ();
    fb_write_arbiter_if #(.PIXEL_WIDTH(PW), .ADDR_WIDTH(AW)) bus1 ();

    assign bus0.blank = blank;             assign bus1.blank = blank;
    assign bus0.clear_start = clear_start; assign bus1.clear_start = clear_start;
    assign bus0.clear_value = clear_value; assign bus1.clear_value = clear_value;
    assign bus0.req0_valid = v0;           assign bus1.req0_valid = v0;
    assign bus0.req0_addr = a0;            assign bus1.req0_addr = a0;
    assign bus0.req0_pixel = p0;           assign bus1.req0_pixel = p0;
    assign bus0.req1_valid = v1;           assign bus1.req1_valid = v1;
    assign bus0.req1_addr = a1;            assign bus1.req1_addr = a1;
    assign bus0.req1_pixel = p1;           assign bus1.req1_pixel = p1;

    fb_write_arbiter #(.PIXEL_WIDTH(PW), .ADDR_WIDTH(AW), .MEM_SIZE(MEM), .BLANK_ONLY(1'b0))
        dut0 (.clk(clk), .reset(reset), .bus(bus0));
    fb_write_arbiter #(.PIXEL_WIDTH(PW), .ADDR_WIDTH(AW), .MEM_SIZE(MEM), .BLANK_ONLY(1'b1))
        dut1 (.clk(clk), .reset(reset), .bus(bus1));

    logic          d_we[2], d_busy[2], d_oor[2], d_r0[2], d_r1[2];
    logic [AW-1:0] d_addr[2];
    logic [PW-1:0] d_pix[2];
    assign d_we[0] = bus0.write_enable;  assign d_we[1] = bus1.write_enable;
    assign d_busy[0] = bus0.clear_busy;  assign d_busy[1] = bus1.clear_busy;
    assign d_oor[0] = bus0.oor_err;      assign d_oor[1] = bus1.oor_err;
    assign d_r0[0] = bus0.req0_ready;    assign d_r0[1] = bus1.req0_ready;
    assign d_r1[0] = bus0.req1_ready;    assign d_r1[1] = bus1.req1_ready;
    assign d_addr[0] = bus0.write_addr;  assign d_addr[1] = bus1.write_addr;
    assign d_pix[0] = bus0.pixel_in;     assign d_pix[1] = bus1.pixel_in;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state per instance: k=0 ignores blank, k=1 writes only during blank.
    bit            m_busy[2];
    int unsigned   m_cnt[2];
    logic [PW-1:0] m_val[2];
    int            m_last[2] = '{1, 1};
    bit            e_we[2], e_oor[2];
    logic [AW-1:0] e_addr[2];
    logic [PW-1:0] e_pix[2];

    function automatic int exp_grant(input int k);
        if (m_busy[k] || clear_start || !(k == 0 || blank)) return -1;
        if (v0 && v1) return 1 - m_last[k];
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    task automatic model_step(input int k);
        int g;
        logic [AW-1:0] a;
        g = exp_grant(k);
        if (reset) begin
            m_busy[k] = 1'b0; m_last[k] = 1; e_we[k] = 1'b0; e_oor[k] = 1'b0;
            e_addr[k] = '0; e_pix[k] = '0;
            return;
        end
        e_we[k] = 1'b0;
        e_oor[k] = 1'b0;
        if (m_busy[k]) begin
            if (k == 0 || blank) begin
                e_we[k] = 1'b1; e_addr[k] = AW'(m_cnt[k]); e_pix[k] = m_val[k];
                if (m_cnt[k] == 32'(MEM - 1)) m_busy[k] = 1'b0;
                m_cnt[k]++;
            end
        end else if (clear_start) begin
            m_busy[k] = 1'b1; m_cnt[k] = 0; m_val[k] = clear_value;
        end else if (g >= 0) begin
            m_last[k] = g;
            a = (g == 1) ? a1 : a0;
            if (a >= AW'(MEM)) e_oor[k] = 1'b1;
            else begin
                e_we[k] = 1'b1; e_addr[k] = a; e_pix[k] = (g == 1) ? p1 : p0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k);
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                int g;
                g = exp_grant(k);
                chk($sformatf("ready0[%0d]", k), 32'(d_r0[k]), 32'(g == 0));
                chk($sformatf("ready1[%0d]", k), 32'(d_r1[k]), 32'(g == 1));
                chk($sformatf("we[%0d]", k), 32'(d_we[k]), 32'(e_we[k]));
                chk($sformatf("busy[%0d]", k), 32'(d_busy[k]), 32'(m_busy[k]));
                chk($sformatf("oor[%0d]", k), 32'(d_oor[k]), 32'(e_oor[k]));
                if (e_we[k]) begin
                    chk($sformatf("addr[%0d]", k), d_addr[k], e_addr[k]);
                    chk($sformatf("pix[%0d]", k), 32'(d_pix[k]), 32'(e_pix[k]));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int exp_seq[6] = '{0, 1, 0, 1, 0, 1};
    bit bpat[12] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0};

    initial begin
        int nw, nb, nr, bad, nr_on, nr_off, nw_off;
        int unsigned expa;
        bit prev_blank, found;

        // 1: reset, then simultaneous requests
        tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_we", 32'(d_we[k]), 32'd0);
            chk("rst_addr", d_addr[k], 32'd0);
            chk("rst_pix", 32'(d_pix[k]), 32'd0);
            chk("rst_busy", 32'(d_busy[k]), 32'd0);
            chk("rst_oor", 32'(d_oor[k]), 32'd0);
        end
        tick();

        // 2: both held valid for six cycles -> alternate grants
        v0 = 1'b1; a0 = 32'd10; p0 = 12'h111;
        v1 = 1'b1; a1 = 32'd20; p1 = 12'h222;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rr_grant1", 32'(d_r1[0]), 32'(exp_seq[i]));
            chk("rr_grant0", 32'(d_r0[0]), 32'(1 - exp_seq[i]));
            if (i > 0) begin
                chk("rr_we", 32'(d_we[0]), 32'd1);
                chk("rr_addr", d_addr[0], (exp_seq[i-1] == 1) ? 32'd20 : 32'd10);
            end
            tick();
        end
        v0 = 1'b0; v1 = 1'b0;
        @(negedge clk);
        chk("rr_last_addr", d_addr[0], 32'd20);
        chk("rr_last_pix", 32'(d_pix[0]), 32'h222);
        tick();

        // 3: full clear, request held throughout, second clear_start ignored
        clear_value = 12'hABC; clear_start = 1'b1;
        v0 = 1'b1; a0 = 32'd5; p0 = 12'h007;
        @(negedge clk);
        chk("clr_beats_req", 32'(d_r0[0]), 32'd0);
        tick();
        clear_start = 1'b0;
        nw = 0; nb = 0; nr = 0; bad = 0; expa = 0;
        for (int i = 1; i <= 2501; i++) begin
            clear_start = (i == 50);
            @(negedge clk);
            if (d_busy[0]) nb++;
            if (d_busy[0] && (d_r0[0] || d_r1[0])) nr++;
            if (d_we[0]) begin
                if (d_addr[0] != AW'(expa) || d_pix[0] != 12'hABC) bad++;
                expa++;
                nw++;
            end
            if (i < 2501) tick();
        end
        chk("clr_writes", 32'(nw), 32'd2500);
        chk("clr_busy_cycles", 32'(nb), 32'd2500);
        chk("clr_readies", 32'(nr), 32'd0);
        chk("clr_addr_errs", 32'(bad), 32'd0);
        chk("clr_done_ready", 32'(d_r0[0]), 32'd1);
        tick();

        // 4: BLANK_ONLY instance, blank 3 on / 3 off
        a0 = 32'd33; p0 = 12'h044;
        nr_on = 0; nr_off = 0; nw = 0; nw_off = 0; prev_blank = 1'b1;
        for (int i = 0; i <= 12; i++) begin
            blank = (i < 12) ? bpat[i] : 1'b0;
            @(negedge clk);
            if (d_r0[1]) begin
                if (blank) nr_on++;
                else nr_off++;
            end
            if (i > 0 && d_we[1]) begin
                nw++;
                if (!prev_blank) nw_off++;
            end
            prev_blank = blank;
            tick();
        end
        v0 = 1'b0; blank = 1'b1;
        chk("blank_ready_on", 32'(nr_on), 32'd6);
        chk("blank_ready_off", 32'(nr_off), 32'd0);
        chk("blank_writes", 32'(nw), 32'd6);
        chk("blank_writes_off", 32'(nw_off), 32'd0);
        tick();

        // 5: out-of-range address
        v1 = 1'b1; a1 = 32'd2500; p1 = 12'h005;
        @(negedge clk);
        chk("oor_ready_0", 32'(d_r1[0]), 32'd1);
        chk("oor_ready_1", 32'(d_r1[1]), 32'd1);
        tick();
        v1 = 1'b0;
        @(negedge clk);
        chk("oor_we", 32'(d_we[0]), 32'd0);
        chk("oor_pulse", 32'(d_oor[0]), 32'd1);
        tick();
        @(negedge clk);
        chk("oor_pulse_end", 32'(d_oor[0]), 32'd0);
        tick();

        // 6: reset in the middle of a clear, then restart
        clear_value = 12'h123; clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (d_we[0] && d_addr[0] == 32'd100) found = 1'b1;
            else tick();
        end
        chk("clr_100_seen", 32'(found), 32'd1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("abort_we", 32'(d_we[0]), 32'd0);
        chk("abort_busy", 32'(d_busy[0]), 32'd0);
        tick();
        clear_value = 12'h456; clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        @(negedge clk);
        chk("restart_busy", 32'(d_busy[0]), 32'd1);
        chk("restart_we0", 32'(d_we[0]), 32'd0);
        tick();
        @(negedge clk);
        chk("restart_we", 32'(d_we[0]), 32'd1);
        chk("restart_addr", d_addr[0], 32'd0);
        chk("restart_pix", 32'(d_pix[0]), 32'h456);
        tick();
        reset = 1'b1;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
